threshold_window_detector: RTL and testbench



---
 rtl/threshold_window_detector.sv | 166 ++++++++++++++++
 tb/tb_threshold_window_detector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/threshold_window_detector.sv
// threshold_window_detector
//
// Streaming debounce/voting stage. Each accepted sample is flagged as a hit
// when its popcount reaches THRESH. The last WIN hit flags are kept in a
// shift register, and a running count of hits inside that window is
// maintained. The window output asserts once WIN samples have been seen and
// the count reaches WIN_THRESH. All outputs are registered, one cycle after
// the accepted sample.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   clear      synchronous window flush (wins over a simultaneous sample)
//   in_val     in carries a valid sample this cycle
//   in         NBITS-wide sample vector
//   out_val    one-cycle pulse: outputs were updated by last cycle's sample
//   hit        per-sample detection, popcount(in) >= THRESH
//   win_count  number of hits in the current window
//   out        window detection (window full and win_count >= WIN_THRESH)
//   full       WIN samples accumulated since reset/clear
module threshold_window_detector #(
    parameter int NBITS      = 3,
    parameter int THRESH     = 2,
    parameter int WIN        = 4,
    parameter int WIN_THRESH = 3,
    localparam int PW = $clog2(NBITS + 1),
    localparam int CW = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_val,
    input  logic [NBITS-1:0] in,
    output logic             out_val,
    output logic             hit,
    output logic [CW-1:0]    win_count,
    output logic             out,
    output logic             full
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [WIN-1:0]  hist_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   fill_q;
    logic            out_val_q;
    logic            hit_q;
    logic            out_q;
    logic            full_q;

    logic            det_d;
    logic            oldest_d;
    logic [WIN-1:0]  hist_d;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   fill_d;
    logic            fill_done_d;
    logic            full_d;
    logic            out_d;

    function automatic logic [PW-1:0] popcount(input logic [NBITS-1:0] v);
        logic [PW-1:0] acc;
        acc = {PW{1'b0}};
        for (int i = 0; i < NBITS; i++) begin
            acc = acc + PW'(v[i]);
        end
        return acc;
    endfunction

    // Next-state values for an accepted sample.
    always_comb begin
        det_d       = (popcount(in) >= PW'(THRESH));
        oldest_d    = 1'b0;
        fill_d      = fill_q + CW'(1);
        fill_done_d = 1'b0;
        full_d      = 1'b0;

        // Bit leaving the window only counts once the window is full; in
        // FILL the history tail is still zero from reset/clear anyway.
        case (state_q)
            S_FILL: begin
                oldest_d    = 1'b0;
                fill_done_d = (fill_d == CW'(WIN));
                full_d      = fill_done_d;
            end
            S_RUN: begin
                oldest_d    = hist_q[WIN-1];
                fill_done_d = 1'b0;
                full_d      = 1'b1;
            end
            default: begin
                oldest_d    = 1'b0;
                fill_done_d = 1'b0;
                full_d      = 1'b0;
            end
        endcase

        hist_d = hist_q;
        for (int i = WIN - 1; i > 0; i--) begin
            hist_d[i] = hist_q[i-1];
        end
        hist_d[0] = det_d;

        // Intermediate wrap in CW bits is harmless: the true result is 0..WIN.
        cnt_d = cnt_q + CW'(det_d) - CW'(oldest_d);
        out_d = full_d && (cnt_d >= CW'(WIN_THRESH));
    end

    // FILL/RUN state machine with history, count and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FILL;
            hist_q    <= {WIN{1'b0}};
            cnt_q     <= {CW{1'b0}};
            fill_q    <= {CW{1'b0}};
            out_val_q <= 1'b0;
            hit_q     <= 1'b0;
            out_q     <= 1'b0;
            full_q    <= 1'b0;
        end else if (clear) begin
            state_q   <= S_FILL;
            hist_q    <= {WIN{1'b0}};
            cnt_q     <= {CW{1'b0}};
            fill_q    <= {CW{1'b0}};
            out_val_q <= 1'b0;
            hit_q     <= 1'b0;
            out_q     <= 1'b0;
            full_q    <= 1'b0;
        end else if (in_val) begin
            out_val_q <= 1'b1;
            hit_q     <= det_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            full_q    <= full_d;
            case (state_q)
                S_FILL: begin
                    fill_q <= fill_d;
                    if (fill_done_d) begin
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_FILL;
                    end
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end else begin
            out_val_q <= 1'b0;
        end
    end

    assign out_val   = out_val_q;
    assign hit       = hit_q;
    assign win_count = cnt_q;
    assign out       = out_q;
    assign full      = full_q;

endmodule

// File: tb/tb_threshold_window_detector.sv
// Directed self-checking bench for threshold_window_detector: one instance
// with default parameters and one with NBITS=8, THRESH=5, WIN=8,
// WIN_THRESH=6. Expected values are hand-computed constants.
module tb_threshold_window_detector;

    logic       clk;
    logic       reset;

    logic       clear1;
    logic       in_val1;
    logic [2:0] in1;
    logic       out_val1;
    logic       hit1;
    logic [2:0] win_count1;
    logic       out1;
    logic       full1;

    logic       clear2;
    logic       in_val2;
    logic [7:0] in2;
    logic       out_val2;
    logic       hit2;
    logic [3:0] win_count2;
    logic       out2;
    logic       full2;

    int n_checks = 0;
    int n_errors = 0;

    threshold_window_detector dut1 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear1),
        .in_val    (in_val1),
        .in        (in1),
        .out_val   (out_val1),
        .hit       (hit1),
        .win_count (win_count1),
        .out       (out1),
        .full      (full1)
    );

    threshold_window_detector #(
        .NBITS      (8),
        .THRESH     (5),
        .WIN        (8),
        .WIN_THRESH (6)
    ) dut2 (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear2),
        .in_val    (in_val2),
        .in        (in2),
        .out_val   (out_val2),
        .hit       (hit2),
        .win_count (win_count2),
        .out       (out2),
        .full      (full2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic v, input logic h,
                        input logic [2:0] c, input logic o, input logic f);
        chk({tag, ".out_val"},   32'(out_val1),   32'(v));
        chk({tag, ".hit"},       32'(hit1),       32'(h));
        chk({tag, ".win_count"}, 32'(win_count1), 32'(c));
        chk({tag, ".out"},       32'(out1),       32'(o));
        chk({tag, ".full"},      32'(full1),      32'(f));
    endtask

    task automatic chk2(input string tag, input logic v, input logic h,
                        input logic [3:0] c, input logic o, input logic f);
        chk({tag, ".out_val"},   32'(out_val2),   32'(v));
        chk({tag, ".hit"},       32'(hit2),       32'(h));
        chk({tag, ".win_count"}, 32'(win_count2), 32'(c));
        chk({tag, ".out"},       32'(out2),       32'(o));
        chk({tag, ".full"},      32'(full2),      32'(f));
    endtask

    // Drive one cycle on dut1, return at posedge+1 with in_val released.
    task automatic cyc1(input logic v, input logic [2:0] d);
        in_val1 = v;
        in1     = d;
        @(posedge clk);
        #1;
        in_val1 = 1'b0;
        in1     = 3'bxxx;
    endtask

    task automatic cyc2(input logic v, input logic [7:0] d);
        in_val2 = v;
        in2     = d;
        @(posedge clk);
        #1;
        in_val2 = 1'b0;
        in2     = 8'hxx;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    int t1_cnt [8] = '{0, 0, 0, 1, 1, 2, 3, 3};
    int t1_hit [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    int t1_out [8] = '{0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        reset   = 1'b1;
        clear1  = 1'b0;
        in_val1 = 1'b0;
        in1     = 3'bxxx;
        clear2  = 1'b0;
        in_val2 = 1'b0;
        in2     = 8'hxx;

        // Reset state
        #3;
        chk1("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk2("reset2", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        #9;
        reset = 1'b0;

        // Exhaustive 3-bit vectors, back to back
        for (int i = 0; i < 8; i++) begin
            cyc1(1'b1, 3'(i));
            chk1($sformatf("exh%0d", i), 1'b1, 1'(t1_hit[i]), 3'(t1_cnt[i]),
                 1'(t1_out[i]), (i >= 3) ? 1'b1 : 1'b0);
        end
        // Idle cycle with X on in: outputs hold, out_val falls
        cyc1(1'b0, 3'bxxx);
        chk1("idle_x", 1'b0, 1'b1, 3'd3, 1'b1, 1'b1);

        // Window count / age-out sequence
        pulse_reset();
        cyc1(1'b1, 3'b011); chk1("win_a", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        cyc1(1'b1, 3'b101); chk1("win_b", 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        cyc1(1'b1, 3'b110); chk1("win_c", 1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
        cyc1(1'b1, 3'b000); chk1("win_d", 1'b1, 1'b0, 3'd3, 1'b1, 1'b1);
        cyc1(1'b1, 3'b000); chk1("win_e", 1'b1, 1'b0, 3'd2, 1'b0, 1'b1);
        cyc1(1'b1, 3'b000); chk1("win_f", 1'b1, 1'b0, 3'd1, 1'b0, 1'b1);

        // Clear with a simultaneous sample: sample dropped, FILL restarts
        pulse_reset();
        for (int i = 0; i < 4; i++) cyc1(1'b1, 3'b111);
        chk1("pre_clr", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
        clear1 = 1'b1;
        cyc1(1'b1, 3'b111);
        clear1 = 1'b0;
        chk1("clr", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc1(1'b1, 3'b111);
            chk1($sformatf("refill%0d", i), 1'b1, 1'b1, 3'(i + 1), 1'b0, 1'b0);
        end
        cyc1(1'b1, 3'b111);
        chk1("refill3", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle while in RUN with win_count=3
        cyc1(1'b1, 3'b000);
        chk1("pre_rst", 1'b1, 1'b0, 3'd3, 1'b1, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk1("async_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc1(1'b1, 3'b111);
            chk1($sformatf("post_rst%0d", i), 1'b1, 1'b1, 3'(i + 1), 1'b0, 1'b0);
        end
        cyc1(1'b1, 3'b111);
        chk1("post_rst3", 1'b1, 1'b1, 3'd4, 1'b1, 1'b1);

        // Gapped stream: in_val 1,0,0,1
        pulse_reset();
        cyc1(1'b1, 3'b111); chk1("gap0", 1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        cyc1(1'b0, 3'b111); chk1("gap1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        cyc1(1'b0, 3'b111); chk1("gap2", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        cyc1(1'b1, 3'b111); chk1("gap3", 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);

        // Wide instance: 0x0F/0x1F alternating, then 0xFF ages out the misses
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            cyc2(1'b1, (i % 2 == 0) ? 8'h0F : 8'h1F);
            chk2($sformatf("wide%0d", i), 1'b1, (i % 2 == 1) ? 1'b1 : 1'b0,
                 4'((i + 1) / 2), 1'b0, (i == 7) ? 1'b1 : 1'b0);
        end
        cyc2(1'b1, 8'hFF); chk2("wide_ff0", 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
        cyc2(1'b1, 8'hFF); chk2("wide_ff1", 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
        cyc2(1'b1, 8'hFF); chk2("wide_ff2", 1'b1, 1'b1, 4'd6, 1'b1, 1'b1);
        cyc2(1'b0, 8'hxx); chk2("wide_idle", 1'b0, 1'b1, 4'd6, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
